// File: rtl/ras_control_if.sv
// Fetch-side event inputs and RAS-side strobe outputs of the RAS sequencer.
// The master drives fetch events; the slave (ras_control) produces strobes.
interface ras_control_if #(
  parameter int RAS_ENTRIES = 8
);
  localparam int OCC_W = $clog2(RAS_ENTRIES) + 1;

  // fetch / retire side
  logic              fetch_valid;
  logic              is_branch;
  logic              is_call;
  logic              is_return;
  logic              is_compressed;
  logic [31:0]       pc;
  logic              branch_retired;
  logic              fetch_flush;
  logic              early_flush;

  // RAS storage side and status
  logic              ras_push;
  logic              ras_pop;
  logic [31:0]       ras_new_addr;
  logic              ras_branch_fetched;
  logic              ras_branch_retired;
  logic              predict_valid;
  logic              ckpt_full;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output fetch_valid, is_branch, is_call, is_return, is_compressed, pc,
           branch_retired, fetch_flush, early_flush,
    input  ras_push, ras_pop, ras_new_addr, ras_branch_fetched,
           ras_branch_retired, predict_valid, ckpt_full, occupancy
  );

  modport slave (
    input  fetch_valid, is_branch, is_call, is_return, is_compressed, pc,
           branch_retired, fetch_flush, early_flush,
    output ras_push, ras_pop, ras_new_addr, ras_branch_fetched,
           ras_branch_retired, predict_valid, ckpt_full, occupancy
  );
endinterface

// File: rtl/ras_control.sv
// RAS sequencer: converts fetch call/return/branch events into RAS strobes,
// tracks valid stack occupancy and checkpoints occupancy per in-flight branch
// so that a fetch flush restores it in step with the RAS read index.
module ras_control #(
  parameter int RAS_ENTRIES  = 8,
  parameter int MAX_BRANCHES = 8
) (
  input  logic         clk,
  input  logic         rst,
  ras_control_if.slave bus
);
  localparam int OCC_W = $clog2(RAS_ENTRIES) + 1;
  localparam int OUT_W = $clog2(MAX_BRANCHES + 1);
  localparam int PTR_W = (MAX_BRANCHES > 1) ? $clog2(MAX_BRANCHES) : 1;
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(RAS_ENTRIES);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_BRANCHES);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_BRANCHES - 1);

  logic [OCC_W-1:0] occ_reg, occ_next, occ_upd;
  logic [OUT_W-1:0] out_reg, out_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic             predict_valid_reg;
  logic             ckpt_full_reg;
  logic [OCC_W-1:0] ckpt_mem [MAX_BRANCHES];
  logic [OCC_W-1:0] ckpt_head;

  logic ev, push, pop, fetched, retired;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Event strobes: flush-cycle fetches are dropped, nothing fires in reset.
  assign ev      = bus.fetch_valid & ~bus.fetch_flush & ~rst;
  assign push    = ev & bus.is_call;
  assign pop     = ev & bus.is_return & (occ_reg != '0);
  assign fetched = ev & bus.is_branch;
  assign retired = bus.branch_retired & (out_reg != '0) & ~bus.fetch_flush
                 & ~bus.early_flush & ~rst;

  assign bus.ras_push           = push;
  assign bus.ras_pop            = pop;
  assign bus.ras_branch_fetched = fetched;
  assign bus.ras_branch_retired = retired;
  assign bus.ras_new_addr       = bus.pc + (bus.is_compressed ? 32'd2 : 32'd4);
  assign bus.occupancy          = occ_reg;
  assign bus.predict_valid      = predict_valid_reg;
  assign bus.ckpt_full          = ckpt_full_reg;

  assign ckpt_head = ckpt_mem[rd_ptr_reg];

  // Occupancy after this cycle's push/pop; saturates because the RAS wraps.
  always_comb begin
    occ_upd = occ_reg;
    if (push && !pop) begin
      occ_upd = (occ_reg == OCC_MAX) ? occ_reg : occ_reg + OCC_W'(1);
    end else if (!push && pop) begin
      occ_upd = occ_reg - OCC_W'(1);
    end
  end

  // Next-state for occupancy, outstanding count and checkpoint pointers.
  always_comb begin
    occ_next    = occ_upd;
    out_next    = out_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (bus.fetch_flush) begin
      occ_next    = (out_reg != '0) ? ckpt_head : occ_reg;
      out_next    = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else if (bus.early_flush) begin
      out_next    = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (fetched) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (retired) rd_ptr_next = ptr_inc(rd_ptr_reg);
      if (fetched && !retired) begin
        out_next = out_reg + OUT_W'(1);
      end else if (!fetched && retired) begin
        out_next = out_reg - OUT_W'(1);
      end
    end
  end

  // Checkpoint storage: record the pre-update occupancy of each branch.
  always_ff @(posedge clk) begin
    if (fetched) begin
      ckpt_mem[wr_ptr_reg] <= occ_reg;
    end
  end

  // State registers; status flags are registered from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg           <= '0;
      out_reg           <= '0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      predict_valid_reg <= 1'b0;
      ckpt_full_reg     <= 1'b0;
    end else begin
      occ_reg           <= occ_next;
      out_reg           <= out_next;
      wr_ptr_reg        <= wr_ptr_next;
      rd_ptr_reg        <= rd_ptr_next;
      predict_valid_reg <= (occ_next != '0);
      ckpt_full_reg     <= (out_next == OUT_MAX);
    end
  end
endmodule

// File: tb/tb_ras_control.sv
// Self-checking bench for ras_control: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_ras_control;
  localparam int RAS_ENTRIES  = 8;
  localparam int MAX_BRANCHES = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // behavioural model: occupancy as an integer, checkpoints as a queue
  int   m_occ = 0;
  int   m_q[$];
  bit   m_valid = 1'b0;

  ras_control_if #(.RAS_ENTRIES(RAS_ENTRIES)) bus ();

  ras_control #(
    .RAS_ENTRIES (RAS_ENTRIES),
    .MAX_BRANCHES(MAX_BRANCHES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit fv, input bit br, input bit call, input bit ret,
                       input bit comp, input logic [31:0] p, input bit rt,
                       input bit ff, input bit ef);
    bus.fetch_valid    = fv;
    bus.is_branch      = br;
    bus.is_call        = call;
    bus.is_return      = ret;
    bus.is_compressed  = comp;
    bus.pc             = p;
    bus.branch_retired = rt;
    bus.fetch_flush    = ff;
    bus.early_flush    = ef;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model, then advance the model to the
  // state the DUT will hold after the coming rising edge.
  always @(negedge clk) begin
    bit          e_ev, e_push, e_pop, e_bf, e_br;
    logic [31:0] e_addr;
    int          nocc;
    e_ev   = !rst && bus.fetch_valid && !bus.fetch_flush;
    e_push = e_ev && bus.is_call;
    e_pop  = e_ev && bus.is_return && (m_occ != 0);
    e_bf   = e_ev && bus.is_branch;
    e_br   = !rst && bus.branch_retired && (m_q.size() != 0)
             && !bus.fetch_flush && !bus.early_flush;
    e_addr = bus.pc + (bus.is_compressed ? 32'd2 : 32'd4);
    if (m_valid) begin
      chk("push", 32'(bus.ras_push), 32'(e_push));
      chk("pop", 32'(bus.ras_pop), 32'(e_pop));
      chk("new_addr", bus.ras_new_addr, e_addr);
      chk("branch_fetched", 32'(bus.ras_branch_fetched), 32'(e_bf));
      chk("branch_retired", 32'(bus.ras_branch_retired), 32'(e_br));
      chk("occupancy", 32'(bus.occupancy), 32'(m_occ));
      chk("predict_valid", 32'(bus.predict_valid), 32'(m_occ != 0));
      chk("ckpt_full", 32'(bus.ckpt_full), 32'(m_q.size() == MAX_BRANCHES));
      if (e_bf && m_q.size() == MAX_BRANCHES) begin
        n_fail++;
        $display("FAIL protocol: branch issued with %0d checkpoints outstanding", m_q.size());
      end
    end
    if (rst) begin
      m_occ = 0;
      m_q.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      nocc = m_occ + int'(e_push) - int'(e_pop);
      if (nocc > RAS_ENTRIES) nocc = RAS_ENTRIES;
      if (bus.fetch_flush) begin
        if (m_q.size() != 0) m_occ = m_q[0];
        m_q.delete();
      end else if (bus.early_flush) begin
        m_occ = nocc;
        m_q.delete();
      end else begin
        if (e_br) void'(m_q.pop_front());
        if (e_bf) m_q.push_back(m_occ);
        m_occ = nocc;
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    bit r_fv, r_br, r_call, r_ret, r_comp, r_rt, r_ff, r_ef;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_occupancy", 32'(bus.occupancy), 32'd0);
    chk("reset_predict_valid", 32'(bus.predict_valid), 32'd0);
    chk("reset_ckpt_full", 32'(bus.ckpt_full), 32'd0);

    // call at 0x100, 32-bit
    drive(1, 0, 1, 0, 0, 32'h100, 0, 0, 0); #1;
    chk("call100_push", 32'(bus.ras_push), 32'd1);
    chk("call100_addr", bus.ras_new_addr, 32'h104);
    tick(); idle(); #1;
    chk("call100_occ", 32'(bus.occupancy), 32'd1);
    chk("call100_pv", 32'(bus.predict_valid), 32'd1);

    drive(1, 0, 0, 1, 0, 32'h104, 0, 0, 0); #1;
    chk("ret_pop", 32'(bus.ras_pop), 32'd1);
    tick(); idle(); #1;
    chk("ret_occ", 32'(bus.occupancy), 32'd0);

    // return on empty stack
    drive(1, 0, 0, 1, 0, 32'h108, 0, 0, 0); #1;
    chk("empty_ret_pop", 32'(bus.ras_pop), 32'd0);
    chk("empty_ret_pv", 32'(bus.predict_valid), 32'd0);
    tick();

    // compressed call at 0x200 then return
    drive(1, 0, 1, 0, 1, 32'h200, 0, 0, 0); #1;
    chk("call200_addr", bus.ras_new_addr, 32'h202);
    tick();
    drive(1, 0, 0, 1, 0, 32'h300, 0, 0, 0); #1;
    chk("ret200_pop", 32'(bus.ras_pop), 32'd1);
    tick(); idle(); #1;
    chk("ret200_occ", 32'(bus.occupancy), 32'd0);

    // nine calls saturate, then coroutine at full
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 1, 0, 0, 32'h1000 + 32'(i * 4), 0, 0, 0);
      tick();
    end
    idle(); #1;
    chk("saturate_occ", 32'(bus.occupancy), 32'd8);
    drive(1, 0, 1, 1, 0, 32'h2000, 0, 0, 0); #1;
    chk("coroutine_push", 32'(bus.ras_push), 32'd1);
    chk("coroutine_pop", 32'(bus.ras_pop), 32'd1);
    tick(); idle(); #1;
    chk("coroutine_occ", 32'(bus.occupancy), 32'd8);

    // checkpoint capacity
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 0, 0, 32'h3000 + 32'(i * 4), 0, 0, 0);
      #1;
      chk("fill_not_full", 32'(bus.ckpt_full), 32'd0);
      tick();
    end
    idle(); #1;
    chk("full_after_8", 32'(bus.ckpt_full), 32'd1);
    drive(0, 0, 0, 0, 0, 32'h0, 1, 0, 0); #1;
    chk("retire_strobe", 32'(bus.ras_branch_retired), 32'd1);
    tick(); idle(); #1;
    chk("retire_clears_full", 32'(bus.ckpt_full), 32'd0);
    drive(1, 1, 0, 0, 0, 32'h3100, 1, 0, 0);
    tick(); idle(); #1;
    chk("fetch_retire_same", 32'(bus.ckpt_full), 32'd0);
    drive(1, 1, 0, 0, 0, 32'h3104, 0, 0, 0);
    tick(); idle(); #1;
    chk("full_again", 32'(bus.ckpt_full), 32'd1);

    // fetch_flush restores checkpointed occupancy
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1, 0, 1, 0, 0, 32'h4000, 0, 0, 0); tick();
    drive(1, 0, 1, 0, 0, 32'h4004, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 32'h4008, 0, 0, 0); tick();
    drive(1, 0, 1, 0, 0, 32'h400c, 0, 0, 0); tick();
    drive(1, 0, 1, 0, 0, 32'h4010, 0, 0, 0); tick();
    idle(); #1;
    chk("preflush_occ", 32'(bus.occupancy), 32'd4);
    drive(1, 0, 1, 0, 0, 32'h4014, 0, 1, 0); #1;
    chk("flush_push", 32'(bus.ras_push), 32'd0);
    tick(); idle(); #1;
    chk("flush_occ", 32'(bus.occupancy), 32'd2);
    drive(0, 0, 0, 0, 0, 32'h0, 1, 0, 0); #1;
    chk("flush_no_retire", 32'(bus.ras_branch_retired), 32'd0);
    tick();

    // early_flush with a concurrent call
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 32'h5000 + 32'(i * 4), 0, 0, 0);
      tick();
    end
    drive(1, 0, 1, 0, 0, 32'h5100, 0, 0, 1);
    tick(); idle(); #1;
    chk("early_occ", 32'(bus.occupancy), 32'd1);
    drive(0, 0, 0, 0, 0, 32'h0, 1, 0, 0); #1;
    chk("early_no_retire", 32'(bus.ras_branch_retired), 32'd0);
    tick();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r_fv   = ($urandom % 4) != 0;
      r_call = ($urandom % 4) == 0;
      r_ret  = ($urandom % 4) == 0;
      r_comp = ($urandom % 2) == 0;
      r_rt   = ($urandom % 3) == 0;
      r_ff   = ($urandom % 20) == 0;
      r_ef   = ($urandom % 20) == 0;
      r_br   = (($urandom % 3) == 0) && !r_ef && (m_q.size() < MAX_BRANCHES);
      rst    = (($urandom % 250) == 0);
      drive(r_fv, r_br, r_call, r_ret, r_comp, $urandom, r_rt, r_ff, r_ef);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
